lsu_bus_bridge: RTL and testbench
=================================

Name: lsu_bus_bridge

Overview:
- Load/store unit directly downstream of the core's data-memory port.
- Consumes mem_read/mem_write, address, store data and funct3 from the execute stage.
- Converts each access into a single word-aligned bus transaction with byte enables, and returns size-extended load data.
- Holds the core via stall while the bus transaction is in flight; flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 16, cycles spent in REQ+RESP before the access is aborted with bus_err (minimum 2)
CNT_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  core clock, rising-edge
reset  in  1  asynchronous, active-low; 0 = reset
mem_read  in  1  load request from core
mem_write  in  1  store request from core
addr  in  32  byte address (core ALU result)
wr_data  in  32  store data (rs2)
funct  in  3  instr[14:12]: access size / signedness
rd_data  out  32  extended load result, registered
stall  out  1  core must hold pc/instr while 1
misaligned  out  1  1-cycle pulse: access rejected, no bus activity
bus_err  out  1  1-cycle pulse: access aborted by timeout
bus_req  out  1  bus request
bus_we  out  1  1 = write
bus_addr  out  32  {addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-aligned store data
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read word

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; timeout counter 0. Takes effect immediately, including mid-transaction. bus_req drops without waiting for bus_gnt.
- States: IDLE, REQ, RESP, DONE.
- IDLE, access present (mem_read|mem_write):
  - Aligned: stall=1 combinationally in the same cycle; latch addr/data/funct/we; next=REQ.
  - mem_write has priority when both inputs are 1.
- Alignment:
  - Half (funct[1:0]=01) requires addr[0]=0.
  - Word (funct[1:0]=10 or 11) requires addr[1:0]=00.
  - Byte: always aligned.
- Misaligned access in IDLE:
  - misaligned=1 registered for one cycle; stall=0; no bus_req.
  - rd_data=0; state stays IDLE.
- REQ:
  - bus_req=1; bus_we/bus_addr/bus_be/bus_wdata come from latched values and stay stable until bus_gnt.
  - On bus_gnt: write goes to DONE, read goes to RESP; bus_req deasserts the next cycle.
- RESP:
  - Wait for bus_rvalid, then register the extended rd_data; next=DONE.
  - bus_rvalid while in REQ is ignored.
- DONE: stall=0 for exactly this cycle, so the core advances on the following edge. No new access is started in DONE. Next=IDLE.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT-1 without completion: bus_err pulses 1 cycle, rd_data=0, next=DONE, bus_req drops.
- Minimum latency with gnt and rvalid in the first possible cycle:
  - Store: stall high 2 cycles (IDLE, REQ); DONE releases.
  - Load: stall high 3 cycles.
- Byte enables and store data, with off=addr[1:0]:
  - SB (000): be=4'b0001<<off; wdata={4{wr_data[7:0]}}.
  - SH (001): be=4'b0011<<off; wdata={2{wr_data[15:0]}}.
  - SW (010): be=4'b1111; wdata=wr_data.
  - funct[2] is ignored for stores.
- Load extraction:
  - Byte = bus_rdata[8*off+:8].
  - Half = bus_rdata[16*off[1]+:16].
  - LB (000) sign-extend; LBU (100) zero-extend.
  - LH (001) sign-extend; LHU (101) zero-extend.
  - LW (010) and all other codes: full word.
- rd_data holds its value until the next completed load, misaligned event or timeout.

Test Plan:
- SB addr=0x1003, wr_data=0x000000A5, gnt in REQ's first cycle -> bus_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5, stall high 2 cycles then low in DONE.
- LB addr=0x2001, bus_rdata=0x0000F000, rvalid 3 cycles after gnt -> rd_data=0xFFFFFFF0. Repeat as LBU -> 0x000000F0.
- LH addr=0x3002, bus_rdata=0x8001_1234 -> rd_data=0xFFFF8001. Repeat with LW addr=0x3001 -> misaligned 1-cycle pulse, no bus_req, stall never asserted.
- Load with bus_gnt held 0, TIMEOUT=16 -> bus_err pulses at cycle 16 after request, rd_data=0, stall falls in the next (DONE) cycle, bus_req=0.
- Store with bus_gnt held low, reset pulled 0 during REQ -> bus_req/stall go 0 asynchronously. After release, state is IDLE; a new SW completes normally.
- mem_read=mem_write=1, SW addr=0x4000 -> bus_we=1, be=4'b1111, single transaction only.

Source files
------------

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the core's data-memory port and a req/gnt/rvalid bus.
// Each aligned access becomes one word-aligned bus transaction with byte enables.
// Load data is size-extended and registered. The core is stalled while the
// transaction is in flight. Misaligned accesses and bus timeouts are flagged with
// one-cycle pulses.
module lsu_bus_bridge #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  funct,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       lat_off;
  logic [2:0]       lat_funct;

  logic             access;
  logic             aligned;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_ext;

  assign access = mem_read | mem_write;

  // The core is held while a transaction is pending. The IDLE term gives a same-cycle
  // stall, and gating with reset keeps stall low while reset is asserted.
  assign stall = reset & ((state == REQ) || (state == RESP) ||
                          ((state == IDLE) && access && aligned));

  // Size-dependent alignment check on the incoming address
  always_comb begin
    aligned = 1'b1;
    case (funct[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Byte enables and lane-replicated store data for the incoming access
  always_comb begin
    be_next    = 4'b0000;
    wdata_next = 32'h0;
    case (funct[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wr_data[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << addr[1:0];
        wdata_next = {2{wr_data[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wr_data;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned read word
  always_comb begin
    byte_sel = bus_rdata[{lat_off, 3'b000} +: 8];
    half_sel = bus_rdata[{lat_off[1], 4'b0000} +: 16];
    load_ext = bus_rdata;
    case (lat_funct)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  // Transaction FSM with registered bus and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      lat_off    <= 2'b00;
      lat_funct  <= 3'b000;
      rd_data    <= 32'h0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'b0000;
      bus_wdata  <= 32'h0;
    end else begin
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              state     <= REQ;
              tmo_cnt   <= '0;
              lat_off   <= addr[1:0];
              lat_funct <= funct;
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_next;
              bus_wdata <= wdata_next;
            end else begin
              misaligned <= 1'b1;
              rd_data    <= 32'h0;
            end
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= bus_we ? DONE : RESP;
          end else if (tmo_cnt >= TMO_LAST) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            rd_data <= 32'h0;
            state   <= DONE;
          end
        end
        RESP: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus_rvalid) begin
            rd_data <= load_ext;
            state   <= DONE;
          end else if (tmo_cnt >= TMO_LAST) begin
            bus_err <= 1'b1;
            rd_data <= 32'h0;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge. The expected transaction is queued when the
// access is driven, and it is compared when the bridge raises the request and when it
// releases the stall.
module tb_lsu_bus_bridge;

  typedef struct {
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        chk_lanes;
    logic [31:0] rd;
    int          stalls;
    int          req_cyc;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [2:0]  funct;
  logic [31:0] rd_data;
  logic        stall;
  logic        misaligned;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int   errors;
  int   checks;
  exp_t exp_q[$];

  lsu_bus_bridge #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wr_data    (wr_data),
    .funct      (funct),
    .rd_data    (rd_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs from the expected one
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic exp_t mkExp(input logic [31:0] baddr, input logic [3:0] be,
                                 input logic [31:0] wdata, input logic we,
                                 input logic chk_lanes, input logic [31:0] rd,
                                 input int stalls, input int req_cyc, input logic err);
    exp_t e;
    e.baddr = baddr; e.be = be; e.wdata = wdata; e.we = we; e.chk_lanes = chk_lanes;
    e.rd = rd; e.stalls = stalls; e.req_cyc = req_cyc; e.err = err;
    return e;
  endfunction

  // Drive one core access and act as the bus slave. gnt_wait is the number of request
  // cycles without a grant (negative means the grant never comes). rv_wait is the number
  // of cycles from the grant to rvalid. While the request is pending and ungranted, a
  // bogus rvalid is driven, and the bridge must ignore it.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [2:0] f,
                               input int gnt_wait, input int rv_wait,
                               input logic [31:0] rdata, input exp_t e);
    int   k;
    int   stalls;
    int   req_cyc;
    int   gnt_cyc;
    bit   done;
    exp_t cur;
    exp_q.push_back(e);
    mem_read = rd; mem_write = wr; addr = a; wr_data = wd; funct = f;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #1;
    checkOutput("stall_same_cycle", 32'(stall), 32'd1);
    stalls = 0; req_cyc = 0; gnt_cyc = -1; done = 0; k = 0;
    while (!done && k < 100) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (!stall) begin
        done = 1;
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          checkOutput("stall_cycles", 32'(stalls), 32'(cur.stalls));
          checkOutput("req_cycles", 32'(req_cyc), 32'(cur.req_cyc));
          checkOutput("bus_req_in_done", 32'(bus_req), 32'd0);
          checkOutput("bus_err", 32'(bus_err), 32'(cur.err));
          checkOutput("rd_data", rd_data, cur.rd);
        end
      end else begin
        stalls++;
        if (bus_req) begin
          if (req_cyc == 0 && exp_q.size() != 0) begin
            checkOutput("bus_addr", bus_addr, exp_q[0].baddr);
            checkOutput("bus_we", 32'(bus_we), 32'(exp_q[0].we));
            if (exp_q[0].chk_lanes) begin
              checkOutput("bus_be", 32'(bus_be), 32'(exp_q[0].be));
              checkOutput("bus_wdata", bus_wdata, exp_q[0].wdata);
            end
          end
          req_cyc++;
          if (gnt_wait >= 0 && req_cyc > gnt_wait) begin
            bus_gnt = 1'b1;
            gnt_cyc = k;
          end else begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hDEADBEEF;
          end
        end else if (gnt_cyc >= 0) begin
          bus_rdata  = rdata;
          bus_rvalid = (k == gnt_cyc + rv_wait);
        end
        @(negedge clk); #1;
        k++;
      end
    end
    if (!done) begin
      checkOutput("cycle_bound", 32'd0, 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    // The core still presents the access during the DONE cycle; no new transaction may start
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk); #1;
    checkOutput("no_req_after_done", 32'(bus_req), 32'd0);
    checkOutput("bus_err_pulse_end", 32'(bus_err), 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk); #1;
    checkOutput("idle_stall", 32'(stall), 32'd0);
    checkOutput("idle_bus_req", 32'(bus_req), 32'd0);
  endtask

  // Drive a misaligned load. It must pulse misaligned for one cycle, clear rd_data, and
  // never stall or request the bus.
  task automatic applyMisaligned(input logic [31:0] a, input logic [2:0] f);
    mem_read = 1'b1; mem_write = 1'b0; addr = a; funct = f;
    #1;
    checkOutput("mis_stall_comb", 32'(stall), 32'd0);
    @(negedge clk); #1;
    checkOutput("mis_pulse", 32'(misaligned), 32'd1);
    checkOutput("mis_rd_data", rd_data, 32'h0);
    checkOutput("mis_bus_req", 32'(bus_req), 32'd0);
    checkOutput("mis_stall", 32'(stall), 32'd0);
    mem_read = 1'b0;
    @(negedge clk); #1;
    checkOutput("mis_pulse_end", 32'(misaligned), 32'd0);
    checkOutput("mis_no_req", 32'(bus_req), 32'd0);
  endtask

  // Test sequence
  initial begin
    errors = 0; checks = 0;
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wr_data = 32'h0;
    funct = 3'b000; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #12;
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'h0);
    checkOutput("rst_misaligned", 32'(misaligned), 32'd0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
    checkOutput("rst_bus_be", 32'(bus_be), 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;

    // SB to the top byte lane, minimum latency
    applyStimulus(1'b0, 1'b1, 32'h1003, 32'h000000A5, 3'b000, 0, 1, 32'h0,
                  mkExp(32'h1000, 4'b1000, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h0, 2, 1, 1'b0));
    // LB / LBU with rvalid three cycles after the grant
    applyStimulus(1'b1, 1'b0, 32'h2001, 32'h0, 3'b000, 0, 3, 32'h0000F000,
                  mkExp(32'h2000, 4'b0000, 32'h0, 1'b0, 1'b0, 32'hFFFFFFF0, 5, 1, 1'b0));
    applyStimulus(1'b1, 1'b0, 32'h2001, 32'h0, 3'b100, 0, 3, 32'h0000F000,
                  mkExp(32'h2000, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h000000F0, 5, 1, 1'b0));
    // LH from the upper half after a delayed grant
    applyStimulus(1'b1, 1'b0, 32'h3002, 32'h0, 3'b001, 2, 1, 32'h80011234,
                  mkExp(32'h3000, 4'b0000, 32'h0, 1'b0, 1'b0, 32'hFFFF8001, 5, 3, 1'b0));
    applyMisaligned(32'h3001, 3'b010);
    // LHU from the lower half
    applyStimulus(1'b1, 1'b0, 32'h3000, 32'h0, 3'b101, 0, 1, 32'h80011234,
                  mkExp(32'h3000, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h00001234, 3, 1, 1'b0));
    // SH to the upper half with one ungranted request cycle
    applyStimulus(1'b0, 1'b1, 32'h2002, 32'h0000BEEF, 3'b001, 1, 1, 32'h0,
                  mkExp(32'h2000, 4'b1100, 32'hBEEFBEEF, 1'b1, 1'b1, 32'h00001234, 3, 2, 1'b0));
    // LW with minimum latency
    applyStimulus(1'b1, 1'b0, 32'h3004, 32'h0, 3'b010, 0, 1, 32'h12345678,
                  mkExp(32'h3004, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h12345678, 3, 1, 1'b0));
    applyMisaligned(32'h3003, 3'b001);
    applyStimulus(1'b1, 1'b0, 32'h3008, 32'h0, 3'b010, 0, 2, 32'h0BADF00D,
                  mkExp(32'h3008, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0BADF00D, 4, 1, 1'b0));
    // Load whose grant never arrives: aborted after 16 request cycles
    applyStimulus(1'b1, 1'b0, 32'h5000, 32'h0, 3'b010, -1, 1, 32'h0,
                  mkExp(32'h5000, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0, 17, 16, 1'b0 | 1'b1));
    // Read and write together: a single store transaction
    applyStimulus(1'b1, 1'b1, 32'h4000, 32'hCAFEF00D, 3'b010, 0, 1, 32'h0,
                  mkExp(32'h4000, 4'b1111, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0, 2, 1, 1'b0));

    // Reset asserted in the middle of an ungranted store request
    mem_write = 1'b1; addr = 32'h7000; wr_data = 32'h55AA55AA; funct = 3'b010;
    @(negedge clk); #1;
    checkOutput("pre_rst_req", 32'(bus_req), 32'd1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_req", 32'(bus_req), 32'd0);
    checkOutput("async_rst_stall", 32'(stall), 32'd0);
    @(negedge clk); #1;
    mem_write = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    checkOutput("post_rst_req", 32'(bus_req), 32'd0);
    checkOutput("post_rst_stall", 32'(stall), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h6000, 32'h11223344, 3'b010, 0, 1, 32'h0,
                  mkExp(32'h6000, 4'b1111, 32'h11223344, 1'b1, 1'b1, 32'h0, 2, 1, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
